// File: rtl/mips_defs_pkg.sv
// Package mips_defs: shared constants for the multi-cycle MIPS control path.
//   - opcode constants (IR[31:26])
//   - ula_operation codes consumed by the ALU control decoder
//   - 4-bit control FSM state encoding
//   - ctrl_t: bundle of every control output, so one record can be defaulted and gated
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ULA_ADD   = 4'b0000;
    localparam logic [3:0] ULA_SUB   = 4'b0001;
    localparam logic [3:0] ULA_RTYPE = 4'b0010;
    localparam logic [3:0] ULA_SLTI  = 4'b0011;
    localparam logic [3:0] ULA_ANDI  = 4'b0100;
    localparam logic [3:0] ULA_ORI   = 4'b0101;
    localparam logic [3:0] ULA_XORI  = 4'b0110;
    localparam logic [3:0] ULA_LUI   = 4'b0111;
    localparam logic [3:0] ULA_SLTIU = 4'b1000;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_R_WB     = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_I_WB     = 4'd5;
    localparam logic [3:0] S_MEM_ADDR = 4'd6;
    localparam logic [3:0] S_MEM_RD   = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_LW_WB    = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] ula_operation;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
        logic       bus_error;
    } ctrl_t;

    // ALU operation for an immediate-class opcode; addi (and anything else) adds.
    function automatic logic [3:0] ula_for_imm(input logic [5:0] op);
        case (op)
            OP_SLTI:  return ULA_SLTI;
            OP_SLTIU: return ULA_SLTIU;
            OP_ANDI:  return ULA_ANDI;
            OP_ORI:   return ULA_ORI;
            OP_XORI:  return ULA_XORI;
            OP_LUI:   return ULA_LUI;
            default:  return ULA_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multiciclo_control_watchdog.sv
// mem_watchdog: counts cycles a memory request stays unanswered.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   active_i     : a memory-request state is current
//   ready_i      : memory completes the access this cycle
//   expire_o     : one-cycle pulse when the wait count has reached WAIT_MAX
//                  (a ready in the same cycle suppresses it)
module mem_watchdog #(
    parameter int WAIT_MAX = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic active_i,
    input  logic ready_i,
    output logic expire_o
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire_o = active_i && !ready_i && (cnt_q == CW'(WAIT_MAX));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!active_i || ready_i || expire_o) cnt_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multiciclo_control.sv
// multiciclo_control: main control FSM of the multi-cycle MIPS core.
//   clock, reset  : rising-edge clock, synchronous active-high reset
//   opcode        : IR[31:26], stable from DECODE to the end of the instruction
//   zero          : ALU zero flag (branch resolution happens in the datapath)
//   mem_ready     : shared memory port completes the access this cycle
//   outputs       : datapath steering/strobes, decoded from the current state;
//                   illegal / bus_error are single-cycle fault pulses.
// All outputs are forced low while reset is high.
module multiciclo_control
    import mips_defs::*;
#(
    parameter int WAIT_MAX = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] ula_operation,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       bus_error
);
    logic [3:0] state_q, state_d;
    ctrl_t      c;
    logic       wd_active, wd_expire;

    // The branch decision is taken by the datapath from pc_write_cond/branch_ne.
    logic unused_zero;
    assign unused_zero = zero;

    assign wd_active = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

    mem_watchdog #(.WAIT_MAX(WAIT_MAX)) u_wd (
        .clock    (clock),
        .reset    (reset),
        .active_i (wd_active),
        .ready_i  (mem_ready),
        .expire_o (wd_expire)
    );

    always_comb begin
        c       = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.alu_src_b = 2'b01;
                if (mem_ready) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE:                    state_d = S_EXEC_R;
                    OP_LW, OP_SW:                state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE:              state_d = S_BRANCH;
                    OP_J:                        state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
                    OP_ORI, OP_XORI, OP_LUI:     state_d = S_EXEC_I;
                    default: begin
                        c.illegal = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                c.alu_src_a     = 1'b1;
                c.ula_operation = ULA_RTYPE;
                state_d         = S_R_WB;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC_I: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b10;
                c.ula_operation = ula_for_imm(opcode);
                state_d         = S_I_WB;
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                state_d     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
                if (mem_ready) state_d = S_LW_WB;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.i_or_d  = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_LW_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.ula_operation = ULA_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = 2'b01;
                c.branch_ne     = (opcode == OP_BNE);
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = 2'b10;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Watchdog abort: expiry only fires without mem_ready, so no IR/PC/reg
        // strobe is live here; just drop the write strobe and restart fetch.
        if (wd_expire) begin
            c.bus_error = 1'b1;
            c.mem_we    = 1'b0;
            state_d     = S_FETCH;
        end

        if (reset) c = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign mem_req       = c.mem_req;
    assign mem_we        = c.mem_we;
    assign i_or_d        = c.i_or_d;
    assign ir_write      = c.ir_write;
    assign pc_write      = c.pc_write;
    assign pc_write_cond = c.pc_write_cond;
    assign branch_ne     = c.branch_ne;
    assign pc_src        = c.pc_src;
    assign alu_src_a     = c.alu_src_a;
    assign alu_src_b     = c.alu_src_b;
    assign ula_operation = c.ula_operation;
    assign reg_write     = c.reg_write;
    assign reg_dst       = c.reg_dst;
    assign mem_to_reg    = c.mem_to_reg;
    assign illegal       = c.illegal;
    assign bus_error     = c.bus_error;
endmodule

// File: tb/tb_multiciclo_control.sv
// Cycle-by-cycle check of the control FSM: each cycle pushes the expected
// control word to a scoreboard queue, then pops and compares it with the DUT.
module tb_multiciclo_control;
    logic       clock, reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal, bus_error;
    logic [3:0] ula_operation;

    int total = 0;
    int bad   = 0;

    logic [21:0] sb_q[$];
    string       tag_q[$];

    multiciclo_control #(.WAIT_MAX(4)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ula_operation(ula_operation), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_error(bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Field order: req we iod irw pcw pcwc bne pcsrc[2] a b[2] op[4] rw rd m2r ill berr
    function automatic logic [21:0] mk(input bit req, we, iod, irw, pcw, pcwc, bne,
                                       input logic [1:0] pcsrc, input bit a,
                                       input logic [1:0] b, input logic [3:0] op,
                                       input bit rw, rd, m2r, ill, berr);
        return {req, we, iod, irw, pcw, pcwc, bne, pcsrc, a, b, op, rw, rd, m2r, ill, berr};
    endfunction

    function automatic logic [21:0] got_word();
        return {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, branch_ne,
                pc_src, alu_src_a, alu_src_b, ula_operation, reg_write, reg_dst,
                mem_to_reg, illegal, bus_error};
    endfunction

    // Expected words for each control step
    function automatic logic [21:0] e_fetch(input bit rdy);
        return mk(1, 0, 0, rdy, rdy, 0, 0, 2'b00, 0, 2'b01, 4'b0000, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [21:0] e_dec(input bit ill);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b11, 4'b0000, 0, 0, 0, ill, 0);
    endfunction
    function automatic logic [21:0] e_exi(input logic [3:0] op);
        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, op, 0, 0, 0, 0, 0);
    endfunction
    function automatic logic [21:0] e_br(input bit ne);
        return mk(0, 0, 0, 0, 0, 1, ne, 2'b01, 1, 2'b00, 4'b0001, 0, 0, 0, 0, 0);
    endfunction
    localparam logic [21:0] E_ZERO = 22'd0;
    localparam logic [21:0] E_EXR  = 22'b0000000_00_1_00_0010_00000;
    localparam logic [21:0] E_RWB  = 22'b0000000_00_0_00_0000_11000;
    localparam logic [21:0] E_IWB  = 22'b0000000_00_0_00_0000_10000;
    localparam logic [21:0] E_LWB  = 22'b0000000_00_0_00_0000_10100;
    localparam logic [21:0] E_MRD  = 22'b1010000_00_0_00_0000_00000;
    localparam logic [21:0] E_MWR  = 22'b1110000_00_0_00_0000_00000;
    localparam logic [21:0] E_BERR = 22'b1010000_00_0_00_0000_00001;
    localparam logic [21:0] E_JMP  = 22'b0000100_10_0_00_0000_00000;

    task automatic chk(input string tag, input logic [21:0] got, input logic [21:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: drive inputs, queue expectation, compare, move on.
    task automatic cyc(input string tag, input bit rdy, input bit z, input logic [21:0] e);
        logic [21:0] ex;
        string       tg;
        mem_ready = rdy;
        zero      = z;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        #1;
        ex = sb_q.pop_front();
        tg = tag_q.pop_front();
        chk(tg, got_word(), ex);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 6'b000000;
        @(negedge clock);
        cyc("rst0", 0, 0, E_ZERO);
        cyc("rst1", 0, 0, E_ZERO);
        reset = 1'b0;

        // R-type: fetch wait once, then 4-cycle instruction
        opcode = 6'b000000;
        cyc("fetch_wait", 0, 0, e_fetch(0));
        cyc("r_fetch",    1, 0, e_fetch(1));
        cyc("r_dec",      0, 0, e_dec(0));
        cyc("r_exec",     0, 0, E_EXR);
        cyc("r_wb",       0, 0, E_RWB);

        // lw with 3 wait cycles in MEM_RD: 8 cycles
        opcode = 6'b100011;
        cyc("lw_fetch", 1, 0, e_fetch(1));
        cyc("lw_dec",   0, 0, e_dec(0));
        cyc("lw_addr",  0, 0, e_exi(4'b0000));
        for (int i = 0; i < 3; i++) cyc($sformatf("lw_wait%0d", i), 0, 0, E_MRD);
        cyc("lw_rd",    1, 0, E_MRD);
        cyc("lw_wb",    0, 0, E_LWB);

        // beq then bne, both with zero=1
        opcode = 6'b000100;
        cyc("beq_fetch", 1, 1, e_fetch(1));
        cyc("beq_dec",   0, 1, e_dec(0));
        cyc("beq_br",    0, 1, e_br(0));
        opcode = 6'b000101;
        cyc("bne_fetch", 1, 1, e_fetch(1));
        cyc("bne_dec",   0, 1, e_dec(0));
        cyc("bne_br",    0, 1, e_br(1));

        // jump
        opcode = 6'b000010;
        cyc("j_fetch", 1, 0, e_fetch(1));
        cyc("j_dec",   0, 0, e_dec(0));
        cyc("j_jump",  0, 0, E_JMP);

        // immediates: slti, sltiu, lui
        opcode = 6'b001010;
        cyc("slti_fetch", 1, 0, e_fetch(1));
        cyc("slti_dec",   0, 0, e_dec(0));
        cyc("slti_exec",  0, 0, e_exi(4'b0011));
        cyc("slti_wb",    0, 0, E_IWB);
        opcode = 6'b001011;
        cyc("sltiu_fetch", 1, 0, e_fetch(1));
        cyc("sltiu_dec",   0, 0, e_dec(0));
        cyc("sltiu_exec",  0, 0, e_exi(4'b1000));
        cyc("sltiu_wb",    0, 0, E_IWB);
        opcode = 6'b001111;
        cyc("lui_fetch", 1, 0, e_fetch(1));
        cyc("lui_dec",   0, 0, e_dec(0));
        cyc("lui_exec",  0, 0, e_exi(4'b0111));
        cyc("lui_wb",    0, 0, E_IWB);

        // illegal opcode: pulse in DECODE, straight back to FETCH
        opcode = 6'b111111;
        cyc("ill_fetch", 1, 0, e_fetch(1));
        cyc("ill_dec",   0, 0, e_dec(1));
        cyc("ill_back",  0, 0, e_fetch(0));

        // sw with memory never ready: 4 waits counted, bus_error on the 5th
        opcode = 6'b101011;
        cyc("sw_fetch", 1, 0, e_fetch(1));
        cyc("sw_dec",   0, 0, e_dec(0));
        cyc("sw_addr",  0, 0, e_exi(4'b0000));
        for (int i = 0; i < 4; i++) cyc($sformatf("sw_wait%0d", i), 0, 0, E_MWR);
        cyc("sw_buserr", 0, 0, E_BERR);
        cyc("sw_back",   0, 0, e_fetch(0));

        // reset in the middle of a store: outputs low, then FETCH
        cyc("sw2_fetch", 1, 0, e_fetch(1));
        cyc("sw2_dec",   0, 0, e_dec(0));
        cyc("sw2_addr",  0, 0, e_exi(4'b0000));
        cyc("sw2_wr",    0, 0, E_MWR);
        reset = 1'b1;
        cyc("sw2_rst",   0, 0, E_ZERO);
        reset = 1'b0;
        cyc("sw2_back",  0, 0, e_fetch(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
